residue_mersenne_seq: RTL and testbench

- Multi-cycle, parametrised residue unit computing A mod (2^K − 1) for a W-bit operand. K=3 gives mod 7.
- Consumes CHUNK bits per clock, exploiting 2^K ≡ 1: the residue is the sum of the K-bit digits, reduced with end-around carry.
- Replaces the flat combinational mod-7 tree where operand width makes a single-cycle tree too deep.
- Uses valid/ready handshakes on both sides so it drops into streaming datapaths.

---
 rtl/residue_pkg.sv | 29 ++
 rtl/residue_fold.sv | 30 +++
 rtl/residue_mersenne_seq.sv | 103 ++++++++++
 tb/tb_residue_mersenne_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/residue_pkg.sv
// Shared types and elaboration-time helpers for the Mersenne-modulus residue unit.
package residue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Modulus M = 2^k - 1.
  function automatic int unsigned modulus(input int unsigned k);
    return (32'd1 << k) - 32'd1;
  endfunction

  // End-around-carry passes needed to bring any sw-bit sum below 2^k.
  // Extra passes are harmless: a reduced value passes through unchanged.
  function automatic int unsigned eac_iters(input int unsigned k, input int unsigned sw);
    longint unsigned b;
    int unsigned     n;
    b = (64'd1 << sw) - 64'd1;
    n = 0;
    while (b >= (64'd1 << (k + 1))) begin
      b = ((64'd1 << k) - 64'd1) + (b >> k);
      n++;
    end
    return n + 2;
  endfunction

endpackage

// File: rtl/residue_fold.sv
// Combinational fold: adds NDIG K-bit digits into a K-bit accumulator modulo 2^K - 1.
module residue_fold
  import residue_pkg::*;
#(
  parameter int unsigned K    = 3,
  parameter int unsigned NDIG = 4
) (
  input  logic [K-1:0]      acc_i,
  input  logic [NDIG*K-1:0] digits_i,
  output logic [K-1:0]      acc_o
);

  localparam int unsigned SumW  = K + $clog2(NDIG + 2);
  localparam int unsigned Iters = eac_iters(K, SumW);

  logic [SumW-1:0] sum;

  // Result may be all-ones, which stands for zero until canonicalised.
  always_comb begin
    sum = SumW'(acc_i);
    for (int unsigned i = 0; i < NDIG; i++) begin
      sum = sum + SumW'(digits_i[i*K +: K]);
    end
    for (int unsigned j = 0; j < Iters; j++) begin
      sum = SumW'(sum[K-1:0]) + (sum >> K);
    end
    acc_o = sum[K-1:0];
  end

endmodule

// File: rtl/residue_mersenne_seq.sv
// Multi-cycle A mod (2^K - 1): folds CHUNK bits per clock, valid/ready on both sides.
module residue_mersenne_seq
  import residue_pkg::*;
#(
  parameter int unsigned W     = 48,
  parameter int unsigned CHUNK = 12,
  parameter int unsigned K     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_res
);

  localparam int unsigned NChunk = W / CHUNK;
  localparam int unsigned NDig   = CHUNK / K;
  localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [K-1:0] Mod   = K'(modulus(K));

  if (K < 2) begin : g_bad_k
    $error("K must be at least 2");
  end
  if (CHUNK == 0 || (W % CHUNK) != 0) begin : g_bad_w
    $error("W must be a non-zero multiple of CHUNK");
  end
  if ((CHUNK % K) != 0) begin : g_bad_chunk
    $error("CHUNK must be a multiple of K");
  end

  state_e          state_q;
  logic [W-1:0]    sreg_q;
  logic [K-1:0]    acc_q;
  logic [CntW-1:0] cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [K-1:0]    out_res_q;
  logic [K-1:0]    fold_acc;

  residue_fold #(
    .K   (K),
    .NDIG(NDig)
  ) u_fold (
    .acc_i   (acc_q),
    .digits_i(sreg_q[CHUNK-1:0]),
    .acc_o   (fold_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            sreg_q     <= in_data;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          acc_q  <= fold_acc;
          sreg_q <= sreg_q >> CHUNK;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(NChunk - 1)) begin
            // Result is canonicalised once here so out_res stays stable in DONE.
            out_res_q   <= (fold_acc == Mod) ? '0 : fold_acc;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;

endmodule

// File: tb/tb_residue_mersenne_seq.sv
// Self-checking bench: default (mod 7) and K=4 (mod 15) instances against an A % M model.
module tb_residue_mersenne_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [47:0] a_in_data;
  logic [2:0]  a_out_res;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data;
  logic [3:0]  b_out_res;

  int n_chk  = 0;
  int n_pass = 0;

  residue_mersenne_seq u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_res  (a_out_res)
  );

  residue_mersenne_seq #(
    .W    (16),
    .CHUNK(8),
    .K    (4)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_res  (b_out_res)
  );

  function automatic logic [2:0] ref_a(input logic [47:0] a);
    return 3'(64'(a) % 64'd7);
  endfunction

  function automatic logic [3:0] ref_b(input logic [15:0] a);
    return 4'(32'(a) % 32'd15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic a_run(input logic [47:0] a, input bit noise, output int lat,
                       output logic [2:0] res, output bit busy_ok);
    a_in_valid = 1'b1;
    a_in_data  = a;
    tick();
    a_in_valid = 1'b0;
    lat        = 0;
    busy_ok    = 1'b1;
    while (!a_out_valid && lat < 20) begin
      if (a_in_ready) busy_ok = 1'b0;
      if (noise) begin
        a_in_valid = 1'($urandom_range(0, 1));
        a_in_data  = 48'({$urandom, $urandom});
      end
      tick();
      lat++;
    end
    if (a_in_ready) busy_ok = 1'b0;
    a_in_valid = 1'b0;
    res        = a_out_res;
  endtask

  task automatic b_run(input logic [15:0] a, output int lat, output logic [3:0] res);
    b_in_valid = 1'b1;
    b_in_data  = a;
    tick();
    b_in_valid = 1'b0;
    lat        = 0;
    while (!b_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = b_out_res;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 48'd100;
    tick();
    tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    n_chk++;
    if (a_in_ready !== 1'b1) $display("FAIL reset_a_in_ready got %b want 1", a_in_ready);
    else n_pass++;
    n_chk++;
    if (a_out_valid !== 1'b0) $display("FAIL reset_a_out_valid got %b want 0", a_out_valid);
    else n_pass++;
    n_chk++;
    if (a_out_res !== 3'd0) $display("FAIL reset_a_out_res got %0d want 0", a_out_res);
    else n_pass++;
    n_chk++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_res !== 4'd0)
      $display("FAIL reset_b got rdy=%b vld=%b res=%0d want 1 0 0",
               b_in_ready, b_out_valid, b_out_res);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [47:0] ops [5];
    logic [2:0]  exps[5];
    int          lat;
    logic [2:0]  res;
    bit          busy_ok;
    ops  = '{48'd100, 48'hFFFF_FFFF_FFFF, 48'd7, 48'd0, 48'h8000_0000_0000};
    exps = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd4};
    for (int i = 0; i < 5; i++) begin
      a_run(ops[i], 1'b0, lat, res, busy_ok);
      n_chk++;
      if (lat != 4) $display("FAIL directed_latency op=%h got %0d want 4", ops[i], lat);
      else n_pass++;
      n_chk++;
      if (res !== exps[i]) $display("FAIL directed_res op=%h got %0d want %0d", ops[i], res, exps[i]);
      else n_pass++;
      n_chk++;
      if (!busy_ok) $display("FAIL directed_in_ready op=%h got 1 while busy want 0", ops[i]);
      else n_pass++;
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      n_chk++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
        $display("FAIL directed_release got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] ops[3];
    int          lat;
    logic [2:0]  res;
    bit          busy_ok;
    ops = '{48'd1, 48'd2, 48'd6};
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_run(ops[i], 1'b0, lat, res, busy_ok);
      n_chk++;
      if (res !== ref_a(ops[i]) || lat != 4 || !busy_ok)
        $display("FAIL b2b_op op=%0d got res=%0d lat=%0d busy_ok=%b want res=%0d lat=4 busy_ok=1",
                 ops[i], res, lat, busy_ok, ref_a(ops[i]));
      else n_pass++;
      tick();
      n_chk++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
        $display("FAIL b2b_handshake got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
      else n_pass++;
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int         lat;
    logic [2:0] res;
    bit         busy_ok;
    bit         spurious;
    a_in_valid = 1'b1;
    a_in_data  = 48'd5;
    tick();
    a_in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_res !== 3'd0)
      $display("FAIL abort_reset got rdy=%b vld=%b res=%0d want 1 0 0",
               a_in_ready, a_out_valid, a_out_res);
    else n_pass++;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_out_valid) spurious = 1'b1;
    end
    n_chk++;
    if (spurious) $display("FAIL abort_no_output got out_valid=1 want 0");
    else n_pass++;
    a_run(48'd13, 1'b0, lat, res, busy_ok);
    n_chk++;
    if (res !== 3'd6 || lat != 4)
      $display("FAIL abort_fresh got res=%0d lat=%0d want 6 4", res, lat);
    else n_pass++;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [47:0] op;
    int          lat;
    logic [2:0]  res;
    bit          busy_ok;
    op = 48'h1234_5678_9ABD;
    a_run(op, 1'b0, lat, res, busy_ok);
    n_chk++;
    if (res !== ref_a(op)) $display("FAIL bp_res got %0d want %0d", res, ref_a(op));
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (a_out_valid !== 1'b1 || a_out_res !== ref_a(op) || a_in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got vld=%b res=%0d rdy=%b want 1 %0d 0",
                 i, a_out_valid, a_out_res, a_in_ready, ref_a(op));
      else n_pass++;
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_chk++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
    else n_pass++;
  endtask

  task automatic test_k4();
    int         lat;
    logic [3:0] res;
    b_run(16'd1000, lat, res);
    n_chk++;
    if (lat != 2) $display("FAIL k4_latency got %0d want 2", lat);
    else n_pass++;
    n_chk++;
    if (res !== 4'd10) $display("FAIL k4_res got %0d want 10", res);
    else n_pass++;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    n_chk++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      $display("FAIL k4_release got vld=%b rdy=%b want 0 1", b_out_valid, b_in_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [47:0] a;
    logic [15:0] bv;
    int          lat;
    logic [2:0]  ra;
    logic [3:0]  rb;
    bit          busy_ok;
    for (int i = 0; i < 500; i++) begin
      a = 48'({$urandom, $urandom});
      if (i % 16 == 0) a = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 20));
      a_run(a, 1'b1, lat, ra, busy_ok);
      n_chk++;
      if (ra !== ref_a(a) || lat != 4 || !busy_ok)
        $display("FAIL rand_a op=%h got res=%0d lat=%0d busy_ok=%b want res=%0d lat=4 busy_ok=1",
                 a, ra, lat, busy_ok, ref_a(a));
      else n_pass++;
      repeat ($urandom_range(0, 3)) tick();
      n_chk++;
      if (a_out_valid !== 1'b1 || a_out_res !== ref_a(a))
        $display("FAIL rand_a_stall op=%h got vld=%b res=%0d want 1 %0d",
                 a, a_out_valid, a_out_res, ref_a(a));
      else n_pass++;
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
    end
    b_out_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      bv = 16'($urandom);
      b_run(bv, lat, rb);
      n_chk++;
      if (rb !== ref_b(bv) || lat != 2)
        $display("FAIL rand_b op=%h got res=%0d lat=%0d want res=%0d lat=2", bv, rb, lat, ref_b(bv));
      else n_pass++;
      tick();
    end
    b_out_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_backpressure();
    test_k4();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
